// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - flit encodings, head field layout and width helpers shared by injector, router and sink
package noc_pkg;

  localparam logic [1:0] FLIT_BODY      = 2'b00;
  localparam logic [1:0] FLIT_HEAD      = 2'b01;
  localparam logic [1:0] FLIT_TAIL      = 2'b10;
  localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

  localparam int HEAD_DEST_LSB = 0;

  typedef enum logic [1:0] {
    INJ_IDLE,
    INJ_VC_ALLOC,
    INJ_HEAD,
    INJ_BODY
  } inj_state_t;

  // A single node or VC still needs a one-bit field to keep ports legal.
  function automatic int width_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int head_src_lsb(input int dest_w);
    return dest_w;
  endfunction

  function automatic int head_len_lsb(input int dest_w);
    return 2 * dest_w;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// rtl/noc_credit_counter.sv - credit counter for one downstream VC buffer, with overflow detect
module noc_credit_counter #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // A return arriving with the buffer already fully credited is a protocol error.
  assign overflow = inc && !dec && (count == FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= FULL;
    end else if (inc && !dec && (count != FULL)) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/noc_flit_injector.sv
// rtl/noc_flit_injector.sv - wormhole flit injector with per-VC credits; NOC_INJ_STATS_EN adds stat_pkts/stat_flits
module noc_flit_injector
  import noc_pkg::*;
#(
  parameter int NUM_OF_NODES            = 8,
  parameter int NODE_ID                 = 0,
  parameter int FLIT_DATA_WIDTH         = 16,
  parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
  parameter int VC_BUFFER_DEPTH         = 2,
  parameter int MAX_PKT_LEN             = 7,
  localparam int DEST_W = width_min1(NUM_OF_NODES),
  localparam int VC_W   = width_min1(NUM_OF_VIRTUAL_CHANNELS),
  localparam int LEN_W  = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pkt_valid,
  output logic                               pkt_ready,
  input  logic [DEST_W-1:0]                  pkt_dest,
  input  logic [LEN_W-1:0]                   pkt_len,
  input  logic                               data_valid,
  output logic                               data_ready,
  input  logic [FLIT_DATA_WIDTH-3:0]         data_in,
  output logic                               flit_valid,
  output logic [FLIT_DATA_WIDTH-1:0]         flit_out,
  output logic [VC_W-1:0]                    flit_vc,
  input  logic [NUM_OF_VIRTUAL_CHANNELS-1:0] credit_return,
  output logic                               credit_err
`ifdef NOC_INJ_STATS_EN
  ,
  output logic [31:0]                        stat_pkts,
  output logic [31:0]                        stat_flits
`endif
);

  localparam int NVC     = NUM_OF_VIRTUAL_CHANNELS;
  localparam int PLD_W   = FLIT_DATA_WIDTH - 2;
  localparam int CNT_W   = $clog2(VC_BUFFER_DEPTH + 1);
  localparam int SRC_LSB = head_src_lsb(DEST_W);
  localparam int LEN_LSB = head_len_lsb(DEST_W);

  inj_state_t        state;
  logic [DEST_W-1:0] dest_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  word_cnt;
  logic [VC_W-1:0]   cur_vc;
  logic [VC_W-1:0]   last_vc;

  logic [CNT_W-1:0]  credit [NVC];
  logic [NVC-1:0]    credit_nz;
  logic [NVC-1:0]    dec_vc;
  logic [NVC-1:0]    overflow_vc;

  logic              alloc_found;
  logic [VC_W-1:0]   alloc_vc;
  logic [VC_W-1:0]   cand;
  logic              send;
  logic              last_word;
  logic [1:0]        send_type;
  logic [PLD_W-1:0]  send_payload;
  logic [PLD_W-1:0]  head_payload;

  for (genvar v = 0; v < NVC; v++) begin : g_vc
    noc_credit_counter #(
      .DEPTH (VC_BUFFER_DEPTH),
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .inc      (credit_return[v]),
      .dec      (dec_vc[v]),
      .count    (credit[v]),
      .overflow (overflow_vc[v])
    );
    assign credit_nz[v] = (credit[v] != '0);
    assign dec_vc[v]    = send && (cur_vc == VC_W'(v));
  end

  assign pkt_ready = (state == INJ_IDLE) && !reset;

  // Round-robin: the VC after the one granted last has highest priority.
  always_comb begin
    alloc_found = 1'b0;
    alloc_vc    = '0;
    cand        = '0;
    for (int i = 0; i < NVC; i++) begin
      cand = VC_W'((int'(last_vc) + 1 + i) % NVC);
      if (!alloc_found && credit_nz[cand]) begin
        alloc_found = 1'b1;
        alloc_vc    = cand;
      end
    end
  end

  always_comb begin
    head_payload                           = '0;
    head_payload[HEAD_DEST_LSB +: DEST_W]  = dest_q;
    head_payload[SRC_LSB +: DEST_W]        = DEST_W'(NODE_ID);
    head_payload[LEN_LSB +: LEN_W]         = len_q;
  end

  always_comb begin
    send         = 1'b0;
    last_word    = 1'b0;
    data_ready   = 1'b0;
    send_type    = FLIT_BODY;
    send_payload = '0;
    case (state)
      INJ_HEAD: begin
        send         = 1'b1;
        send_type    = (len_q == '0) ? FLIT_HEAD_TAIL : FLIT_HEAD;
        send_payload = head_payload;
      end
      INJ_BODY: begin
        data_ready = credit_nz[cur_vc];
        if (data_valid && credit_nz[cur_vc]) begin
          send         = 1'b1;
          last_word    = (word_cnt == len_q - LEN_W'(1));
          send_type    = last_word ? FLIT_TAIL : FLIT_BODY;
          send_payload = data_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= INJ_IDLE;
      dest_q     <= '0;
      len_q      <= '0;
      word_cnt   <= '0;
      cur_vc     <= '0;
      last_vc    <= VC_W'(NVC - 1);
      flit_valid <= 1'b0;
      flit_out   <= '0;
      flit_vc    <= '0;
      credit_err <= 1'b0;
    end else begin
      flit_valid <= send;
      if (send) begin
        flit_out <= {send_type, send_payload};
        flit_vc  <= cur_vc;
      end
      if (|overflow_vc) begin
        credit_err <= 1'b1;
      end
      case (state)
        INJ_IDLE: begin
          if (pkt_valid) begin
            dest_q <= pkt_dest;
            len_q  <= (pkt_len > LEN_W'(MAX_PKT_LEN)) ? LEN_W'(MAX_PKT_LEN) : pkt_len;
            state  <= INJ_VC_ALLOC;
          end
        end
        INJ_VC_ALLOC: begin
          if (alloc_found) begin
            cur_vc  <= alloc_vc;
            last_vc <= alloc_vc;
            state   <= INJ_HEAD;
          end
        end
        INJ_HEAD: begin
          word_cnt <= '0;
          state    <= (len_q == '0) ? INJ_IDLE : INJ_BODY;
        end
        INJ_BODY: begin
          if (send) begin
            word_cnt <= word_cnt + LEN_W'(1);
            if (last_word) begin
              state <= INJ_IDLE;
            end
          end
        end
        default: state <= INJ_IDLE;
      endcase
    end
  end

`ifdef NOC_INJ_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_pkts  <= '0;
      stat_flits <= '0;
    end else if (send) begin
      stat_flits <= stat_flits + 32'd1;
      if (send_type != FLIT_BODY) begin
        stat_pkts <= stat_pkts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_flit_injector.sv
// tb/tb_noc_flit_injector.sv - directed vector table plus hand sequences for the flit injector
module tb_noc_flit_injector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic [2:0]  pkt_dest = '0;
  logic [2:0]  pkt_len = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [13:0] data_in = '0;
  logic        flit_valid;
  logic [15:0] flit_out;
  logic [0:0]  flit_vc;
  logic [1:0]  credit_return = '0;
  logic        credit_err;
`ifdef NOC_INJ_STATS_EN
  logic [31:0] stat_pkts;
  logic [31:0] stat_flits;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  noc_flit_injector dut (
    .clk           (clk),
    .reset         (reset),
    .pkt_valid     (pkt_valid),
    .pkt_ready     (pkt_ready),
    .pkt_dest      (pkt_dest),
    .pkt_len       (pkt_len),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .data_in       (data_in),
    .flit_valid    (flit_valid),
    .flit_out      (flit_out),
    .flit_vc       (flit_vc),
    .credit_return (credit_return),
    .credit_err    (credit_err)
`ifdef NOC_INJ_STATS_EN
    ,
    .stat_pkts     (stat_pkts),
    .stat_flits    (stat_flits)
`endif
  );

  typedef struct {
    logic        pv;
    logic [2:0]  dest;
    logic [2:0]  len;
    logic        dv;
    logic [13:0] din;
    logic [1:0]  cr;
    logic        ev;
    logic [15:0] ef;
    logic        ec;
    logic [1:0]  c0;
    logic [1:0]  c1;
  } vec_t;

  vec_t vt [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    pkt_valid     = 1'b0;
    data_valid    = 1'b0;
    credit_return = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_flit(input int budget, output logic got, output logic [15:0] f,
                           output logic [0:0] vc);
    got = 1'b0;
    f   = '0;
    vc  = '0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (flit_valid) begin
        got = 1'b1;
        f   = flit_out;
        vc  = flit_vc;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        got;
    logic [15:0] f;
    logic [0:0]  vc;
    logic        bad;
    logic [13:0] w [4];
    logic [4:0]  p_dest [5];
    logic [0:0]  p_vc [4];

    vt[0]  = '{1'b1, 3'd3, 3'd0, 1'b0, 14'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 2'd2, 2'd2};
    vt[1]  = '{1'b0, 3'd0, 3'd0, 1'b0, 14'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 2'd2, 2'd2};
    vt[2]  = '{1'b0, 3'd0, 3'd0, 1'b0, 14'h0000, 2'b00, 1'b1, 16'hC003, 1'b0, 2'd1, 2'd2};
    vt[3]  = '{1'b0, 3'd0, 3'd0, 1'b0, 14'h0000, 2'b01, 1'b0, 16'hC003, 1'b0, 2'd2, 2'd2};
    vt[4]  = '{1'b1, 3'd5, 3'd3, 1'b0, 14'h0000, 2'b00, 1'b0, 16'hC003, 1'b0, 2'd2, 2'd2};
    vt[5]  = '{1'b0, 3'd0, 3'd0, 1'b0, 14'h0000, 2'b00, 1'b0, 16'hC003, 1'b0, 2'd2, 2'd2};
    vt[6]  = '{1'b0, 3'd0, 3'd0, 1'b1, 14'h1234, 2'b00, 1'b1, 16'h40C5, 1'b1, 2'd2, 2'd1};
    vt[7]  = '{1'b0, 3'd0, 3'd0, 1'b1, 14'h1234, 2'b10, 1'b1, 16'h1234, 1'b1, 2'd2, 2'd1};
    vt[8]  = '{1'b0, 3'd0, 3'd0, 1'b1, 14'h0BCD, 2'b10, 1'b1, 16'h0BCD, 1'b1, 2'd2, 2'd1};
    vt[9]  = '{1'b0, 3'd0, 3'd0, 1'b1, 14'h3FFF, 2'b10, 1'b1, 16'hBFFF, 1'b1, 2'd2, 2'd1};
    vt[10] = '{1'b0, 3'd0, 3'd0, 1'b0, 14'h0000, 2'b10, 1'b0, 16'hBFFF, 1'b1, 2'd2, 2'd2};

    w[0] = 14'h0111; w[1] = 14'h0222; w[2] = 14'h0333; w[3] = 14'h0444;
    p_dest[0] = 5'd1; p_dest[1] = 5'd2; p_dest[2] = 5'd4; p_dest[3] = 5'd7; p_dest[4] = 5'd6;
    p_vc[0] = 1'b0; p_vc[1] = 1'b1; p_vc[2] = 1'b0; p_vc[3] = 1'b1;

    // Reset values while reset is still asserted.
    #12;
    check("rst_pkt_ready", 32'(pkt_ready), 32'd0);
    check("rst_flit_valid", 32'(flit_valid), 32'd0);
    check("rst_flit_out", 32'(flit_out), 32'd0);
    check("rst_flit_vc", 32'(flit_vc), 32'd0);
    check("rst_credit_err", 32'(credit_err), 32'd0);
    check("rst_credit0", 32'(dut.credit[0]), 32'd2);
    check("rst_credit1", 32'(dut.credit[1]), 32'd2);
    check("rst_last_vc", 32'(dut.last_vc), 32'd1);
    do_reset();
    check("idle_pkt_ready", 32'(pkt_ready), 32'd1);

    // HEAD_TAIL latency and a gapless 4-flit packet with same-cycle send/return.
    for (int i = 0; i < 11; i++) begin
      pkt_valid     = vt[i].pv;
      pkt_dest      = vt[i].dest;
      pkt_len       = vt[i].len;
      data_valid    = vt[i].dv;
      data_in       = vt[i].din;
      credit_return = vt[i].cr;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(flit_valid), 32'(vt[i].ev));
      check($sformatf("vec%0d_flit", i), 32'(flit_out), 32'(vt[i].ef));
      check($sformatf("vec%0d_vc", i), 32'(flit_vc), 32'(vt[i].ec));
      check($sformatf("vec%0d_credit0", i), 32'(dut.credit[0]), 32'(vt[i].c0));
      check($sformatf("vec%0d_credit1", i), 32'(dut.credit[1]), 32'(vt[i].c1));
    end
    pkt_valid = 1'b0; data_valid = 1'b0; credit_return = '0;

    // Round-robin VC allocation until credits run out, then a stall.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      check($sformatf("rr%0d_pkt_ready", p), 32'(pkt_ready), 32'd1);
      pkt_valid = 1'b1; pkt_dest = p_dest[p][2:0]; pkt_len = 3'd0;
      tick();
      pkt_valid = 1'b0;
      wait_flit(6, got, f, vc);
      check($sformatf("rr%0d_got", p), 32'(got), 32'd1);
      check($sformatf("rr%0d_flit", p), 32'(f), 32'(16'hC000 | 16'(p_dest[p])));
      check($sformatf("rr%0d_vc", p), 32'(vc), 32'(p_vc[p]));
    end
    pkt_valid = 1'b1; pkt_dest = p_dest[4][2:0]; pkt_len = 3'd0;
    tick();
    pkt_valid = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      tick();
      bad = bad | flit_valid;
    end
    check("stall_no_flit", 32'(bad), 32'd0);
    check("stall_pkt_ready", 32'(pkt_ready), 32'd0);
    credit_return = 2'b01;
    tick();
    credit_return = '0;
    wait_flit(6, got, f, vc);
    check("release_got", 32'(got), 32'd1);
    check("release_flit", 32'(f), 32'h0000C006);
    check("release_vc", 32'(vc), 32'd0);
    check("release_credit0", 32'(dut.credit[0]), 32'd0);

    // Long packet throttled by credits, one flit per returned credit.
    do_reset();
    pkt_valid = 1'b1; pkt_dest = 3'd2; pkt_len = 3'd4;
    data_valid = 1'b1; data_in = w[0];
    tick();
    pkt_valid = 1'b0;
    tick();
    check("long_dr_head", 32'(data_ready), 32'd0);
    tick();
    check("long_head_valid", 32'(flit_valid), 32'd1);
    check("long_head_flit", 32'(flit_out), 32'h00004102);
    check("long_head_vc", 32'(flit_vc), 32'd0);
    check("long_dr_after_head", 32'(data_ready), 32'd1);
    tick();
    check("long_b0_flit", 32'(flit_valid ? flit_out : 16'hDEAD), 32'(w[0]));
    check("long_b0_vc", 32'(flit_vc), 32'd0);
    check("long_dr_drop", 32'(data_ready), 32'd0);
    data_in = w[1];
    for (int k = 1; k < 4; k++) begin
      bad = 1'b0;
      repeat (2) begin
        tick();
        bad = bad | flit_valid | data_ready;
      end
      check($sformatf("long_stall%0d", k), 32'(bad), 32'd0);
      credit_return = 2'b01;
      tick();
      credit_return = '0;
      check($sformatf("long_dr_credit%0d", k), 32'(data_ready), 32'd1);
      tick();
      check($sformatf("long_w%0d_valid", k), 32'(flit_valid), 32'd1);
      check($sformatf("long_w%0d_flit", k), 32'(flit_out),
            32'({(k == 3) ? 2'b10 : 2'b00, w[k]}));
      check($sformatf("long_w%0d_vc", k), 32'(flit_vc), 32'd0);
      check($sformatf("long_w%0d_dr", k), 32'(data_ready), 32'd0);
      if (k < 3) data_in = w[k+1];
    end
    data_valid = 1'b0;
    tick();
    check("long_done_idle", 32'(pkt_ready), 32'd1);

    // Credit overflow is sticky and the counter saturates.
    check("err_before", 32'(credit_err), 32'd0);
    credit_return = 2'b10;
    tick();
    credit_return = '0;
    check("err_set", 32'(credit_err), 32'd1);
    check("err_credit1", 32'(dut.credit[1]), 32'd2);
    credit_return = 2'b01;
    tick();
    tick();
    credit_return = '0;
    tick();
    check("err_sticky", 32'(credit_err), 32'd1);
    check("err_credit0", 32'(dut.credit[0]), 32'd2);

    // Reset in the middle of a packet body.
    pkt_valid = 1'b1; pkt_dest = 3'd3; pkt_len = 3'd5;
    data_valid = 1'b1; data_in = 14'h0AAA;
    tick();
    pkt_valid = 1'b0;
    tick();
    tick();
    tick();
    check("mid_body_valid", 32'(flit_valid), 32'd1);
    check("mid_body_flit", 32'(flit_out), 32'h00000AAA);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(flit_valid), 32'd0);
    check("mid_rst_pkt_ready", 32'(pkt_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    data_valid = 1'b0;
    tick();
    check("post_rst_credit0", 32'(dut.credit[0]), 32'd2);
    check("post_rst_credit1", 32'(dut.credit[1]), 32'd2);
    check("post_rst_err", 32'(credit_err), 32'd0);
    pkt_valid = 1'b1; pkt_dest = 3'd6; pkt_len = 3'd1;
    data_valid = 1'b1; data_in = 14'h0055;
    tick();
    pkt_valid = 1'b0;
    wait_flit(6, got, f, vc);
    check("fresh_got", 32'(got), 32'd1);
    check("fresh_head", 32'(f), 32'h00004046);
    check("fresh_vc", 32'(vc), 32'd0);
    tick();
    data_valid = 1'b0;
    check("fresh_tail_valid", 32'(flit_valid), 32'd1);
    check("fresh_tail", 32'(flit_out), 32'h00008055);
    tick();
    check("fresh_idle", 32'(flit_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
